reg_wb_scheduler: RTL
=====================

Name: reg_wb_scheduler

Overview:
- Shares the register file's single write port between two sources: the main pipeline write-back slot and a multi-cycle auxiliary unit (multiplier / load-multiple sequencer).
- The pipeline write-back always wins the port. Auxiliary results are buffered in a small in-order queue and drained into idle write-port cycles.
- Provides per-register pending flags to the hazard unit.
- Raises a starvation stall request when queued auxiliary writes wait too long.

Parameters:
DATA_W, 32, width of register data (matches the register file word width)
DEPTH, 4, auxiliary write queue entries (power of two, >=2)
MAX_WAIT, 8, consecutive blocked cycles of the queue head before stall_req asserts (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_en  in  1  pipeline write-back request (cannot be back-pressured)
dest_wb  in  4  pipeline destination register
result_wb  in  DATA_W  pipeline write data
aux_valid  in  1  auxiliary write offered
aux_ready  out  1  queue can accept this cycle
aux_dest  in  4  auxiliary destination register
aux_data  in  DATA_W  auxiliary write data
rf_wb_en  out  1  register file write enable
rf_dest  out  4  register file write index
rf_result  out  DATA_W  register file write data
chk_src1  in  4  decode source 1 to check
chk_src2  in  4  decode source 2 to check
chk_dest  in  4  decode destination to check (WAW)
src1_pending  out  1  queued aux write targets chk_src1
src2_pending  out  1  queued aux write targets chk_src2
dest_pending  out  1  queued aux write targets chk_dest
stall_req  out  1  upstream must free the next write-back slot
queue_count  out  clog2(DEPTH+1)  valid queue entries

Behaviour:
- Reset (sync, active-high):
  - Queue emptied; wait counter = 0; FSM to IDLE.
  - While rst=1: rf_wb_en=0, aux_ready=0, stall_req=0, all pending flags 0, queue_count=0.
  - Reset mid-operation discards all queued data. Queued entries are never written.
- Write-port mux (combinational, so the register file captures it in the same cycle):
  - If wb_en=1: rf_wb_en=1, rf_dest=dest_wb, rf_result=result_wb. Pipeline latency is 0.
  - Else if the queue is non-empty: the head is written and popped at the clk edge.
  - Else rf_wb_en=0; rf_dest and rf_result are don't-care.
- Aux handshake:
  - aux_ready = !rst && (queue_count < DEPTH). Fullness is evaluated before any same-cycle pop.
  - Push occurs on aux_valid && aux_ready at the clk edge.
  - Earliest write of an accepted entry is the next cycle.
  - Entries drain in strict FIFO order.
  - aux_dest=15 (PC, not in the register file) is accepted but discarded: not enqueued, never pending.
- Simultaneous push and pop: both take effect; queue_count unchanged. This includes a full queue only if no push is accepted, since aux_ready=0 when full.
- Pending flags:
  - A flag is high when any valid queue entry's dest equals the checked index. This is a purely combinational compare.
  - Index 15 is never pending.
  - Pipeline write-back does not affect the flags. The hazard unit must stall decode on any pending flag, so pipeline writes never collide with queued entries on the same register.
- FSM:
  - IDLE: queue empty. Go to WAIT on the first push.
  - WAIT: queue non-empty.
    - Wait counter increments on each cycle with wb_en=1 (head blocked).
    - Counter clears on each pop.
    - Go to FORCE when the counter reaches MAX_WAIT.
    - Go to IDLE when the queue becomes empty with no push.
  - FORCE: stall_req=1 (Moore output from state).
    - Counter saturates.
    - Go to WAIT on the first pop (counter cleared), or to IDLE if that pop empties the queue with no push.
    - wb_en may still arrive in FORCE; the scheduler keeps stall_req until the head drains.
- queue_count wraps never. Pointers are modulo DEPTH; the full/empty distinction uses the count.

Test Plan:
- Reset check: rst=1 for 2 cycles with aux_valid=1 -> aux_ready=0, rf_wb_en=0, queue_count=0, stall_req=0; after release aux_ready=1.
- Idle drain: cycle 0 push aux_dest=3, aux_data=0xDEAD, wb_en=0 -> cycle 1 rf_wb_en=1, rf_dest=3, rf_result=0xDEAD; queue_count 1->0; src1_pending=1 for chk_src1=3 during cycle 1 only.
- Priority: queue holds {5:0x11}, wb_en=1 dest_wb=2 result_wb=0x22 -> port carries 2/0x22, queue_count stays 1. Next cycle with wb_en=0 -> port 5/0x11.
- Full and ordering: push 4 entries (dest 1..4) under continuous wb_en=1 -> aux_ready=0 at count 4, a 5th offer is not accepted. Drop wb_en -> dests written 1,2,3,4 in order on consecutive cycles.
- Starvation (MAX_WAIT=8): one entry queued, wb_en=1 for 8 cycles -> stall_req=1 from cycle 9 onward, held while wb_en persists. First cycle with wb_en=0 -> entry written, stall_req=0 next cycle.
- Edge cases: aux_dest=15 push -> queue_count unchanged, no write. Reset asserted with 3 entries queued -> entries never written, all pending flags 0 after reset.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// reg_wb_scheduler
// Shares the register file's single write port between the pipeline
// write-back slot and an auxiliary unit. Auxiliary results wait in an
// in-order queue and drain into cycles the pipeline leaves idle.
// Per-register pending flags tell the hazard unit what is still queued.
// A stall request is raised when the queue head is starved for too long.

module reg_wb_scheduler #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en,
    input  logic [3:0]                 dest_wb,
    input  logic [DATA_W-1:0]          result_wb,
    input  logic                       aux_valid,
    output logic                       aux_ready,
    input  logic [3:0]                 aux_dest,
    input  logic [DATA_W-1:0]          aux_data,
    output logic                       rf_wb_en,
    output logic [3:0]                 rf_dest,
    output logic [DATA_W-1:0]          rf_result,
    input  logic [3:0]                 chk_src1,
    input  logic [3:0]                 chk_src2,
    input  logic [3:0]                 chk_dest,
    output logic                       src1_pending,
    output logic                       src2_pending,
    output logic                       dest_pending,
    output logic                       stall_req,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WW-1:0]     wait_cnt, wait_cnt_nxt;

    logic [3:0]        dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    logic              not_empty;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  entry_valid;
    logic [PW-1:0]     offs;

    // Fullness is judged before any same-cycle pop; PC writes are swallowed,
    // and the head drains only when the pipeline leaves the port idle.
    assign not_empty   = (count != '0);
    assign aux_ready   = !rst && (count < CW'(DEPTH));
    assign push        = aux_valid && aux_ready && (aux_dest != 4'd15);
    assign pop         = !rst && !wb_en && not_empty;
    assign queue_count = rst ? '0 : count;
    assign stall_req   = !rst && (state == ST_FORCE);

    // Queue storage and pointers; the count alone separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                dest_q[wr_ptr] <= aux_dest;
                data_q[wr_ptr] <= aux_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write-port mux: the pipeline always wins, otherwise the queue head.
    always_comb begin
        rf_wb_en  = 1'b0;
        rf_dest   = dest_q[rd_ptr];
        rf_result = data_q[rd_ptr];
        if (!rst) begin
            if (wb_en) begin
                rf_wb_en  = 1'b1;
                rf_dest   = dest_wb;
                rf_result = result_wb;
            end else if (not_empty) begin
                rf_wb_en  = 1'b1;
            end
        end
    end

    // Mark which physical slots hold live entries, measured from the head.
    always_comb begin
        entry_valid = '0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PW'(i) - rd_ptr;
            entry_valid[i] = (CW'(offs) < count);
        end
    end

    // Pending flags: any live entry targeting the checked register.
    always_comb begin
        src1_pending = 1'b0;
        src2_pending = 1'b0;
        dest_pending = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i]) begin
                    if (dest_q[i] == chk_src1 && chk_src1 != 4'd15) src1_pending = 1'b1;
                    if (dest_q[i] == chk_src2 && chk_src2 != 4'd15) src2_pending = 1'b1;
                    if (dest_q[i] == chk_dest && chk_dest != 4'd15) dest_pending = 1'b1;
                end
            end
        end
    end

    // Starvation FSM state and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Starvation FSM next state: count blocked head cycles, clear on each pop.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_cnt_nxt = '0;
                if (push) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (pop) begin
                    wait_cnt_nxt = '0;
                    if (count == CW'(1) && !push) state_nxt = ST_IDLE;
                end else if (wb_en) begin
                    wait_cnt_nxt = wait_cnt + WW'(1);
                    if (wait_cnt + WW'(1) >= WW'(MAX_WAIT)) state_nxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (pop) begin
                    wait_cnt_nxt = '0;
                    if (count == CW'(1) && !push) state_nxt = ST_IDLE;
                    else                          state_nxt = ST_WAIT;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

endmodule
